// File: rtl/fu_pipe_wrapper.sv
// Pipelined arithmetic functional unit with a single registered output stage.
// Element-wise ops (ADD/SUB/MUL/shifts/NOP) produce one result per accepted
// beat. Reduction ops (ACC/RMAX/RMIN/MAC) fold L beats into a single result
// using a two-state IDLE/RUN controller.
module fu_pipe_wrapper #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sat_i,
    input  logic [CNT_W-1:0] red_len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_ARSH = 4'd4;
    localparam logic [3:0] OP_LRSH = 4'd5;
    localparam logic [3:0] OP_LSH  = 4'd6;
    localparam logic [3:0] OP_ACC  = 4'd7;
    localparam logic [3:0] OP_RMAX = 4'd8;
    localparam logic [3:0] OP_RMIN = 4'd9;
    localparam logic [3:0] OP_MAC  = 4'd10;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_RUN  = 1'b1;

    // Add or subtract on WIDTH+1 bits; returns {ovf, result}, clamping when sat is set.
    function automatic logic [WIDTH:0] addSub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic doSub,
                                              input logic sat);
        logic [WIDTH:0]   sum;
        logic             ovf;
        logic [WIDTH-1:0] res;
        if (doSub) sum = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        else       sum = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        ovf = sum[WIDTH] ^ sum[WIDTH-1];
        res = sum[WIDTH-1:0];
        if (ovf && sat) res = sum[WIDTH] ? MIN_NEG : MAX_POS;
        return {ovf, res};
    endfunction

    // Full signed product; overflow when the upper half is not a sign extension.
    function automatic logic [WIDTH:0] mulSat(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic sat);
        logic signed [2*WIDTH-1:0] xs;
        logic signed [2*WIDTH-1:0] ys;
        logic signed [2*WIDTH-1:0] prod;
        logic [WIDTH:0]            topBits;
        logic                      ovf;
        logic [WIDTH-1:0]          res;
        xs      = {{WIDTH{x[WIDTH-1]}}, x};
        ys      = {{WIDTH{y[WIDTH-1]}}, y};
        prod    = xs * ys;
        topBits = prod[2*WIDTH-1:WIDTH-1];
        ovf     = !((&topBits) || (~|topBits));
        res     = prod[WIDTH-1:0];
        if (ovf && sat) res = prod[2*WIDTH-1] ? MIN_NEG : MAX_POS;
        return {ovf, res};
    endfunction

    // One-cycle element-wise operation; opcodes outside the table act as NOP.
    function automatic logic [WIDTH:0] elemOp(input logic [3:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic sat);
        logic [SHW-1:0]   shamt;
        logic [WIDTH-1:0] shifted;
        logic [WIDTH:0]   result;
        shamt   = y[SHW-1:0];
        shifted = '0;
        result  = '0;
        case (op)
            OP_NOP:  result = '0;
            OP_ADD:  result = addSub(x, y, 1'b0, sat);
            OP_SUB:  result = addSub(x, y, 1'b1, sat);
            OP_MUL:  result = mulSat(x, y, sat);
            OP_ARSH: begin
                shifted = $signed(x) >>> shamt;
                result  = {1'b0, shifted};
            end
            OP_LRSH: begin
                shifted = x >> shamt;
                result  = {1'b0, shifted};
            end
            OP_LSH: begin
                shifted = x << shamt;
                result  = {1'b0, shifted};
            end
            default: result = '0;
        endcase
        return result;
    endfunction

    // First term loaded into the accumulator when a reduction starts.
    function automatic logic [WIDTH:0] redFirst(input logic [3:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic sat);
        logic [WIDTH:0] result;
        if (op == OP_MAC) result = mulSat(x, y, sat);
        else              result = {1'b0, x};
        return result;
    endfunction

    // Fold one further beat into the accumulator; MAC reports product and sum overflow.
    function automatic logic [WIDTH:0] redStep(input logic [3:0] op,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic sat);
        logic [WIDTH:0] prod;
        logic [WIDTH:0] sum;
        logic [WIDTH:0] result;
        prod   = '0;
        sum    = '0;
        result = {1'b0, acc};
        case (op)
            OP_ACC:  result = addSub(acc, x, 1'b0, sat);
            OP_MAC: begin
                prod   = mulSat(x, y, sat);
                sum    = addSub(acc, prod[WIDTH-1:0], 1'b0, sat);
                result = {prod[WIDTH] | sum[WIDTH], sum[WIDTH-1:0]};
            end
            OP_RMAX: result = {1'b0, ($signed(x) > $signed(acc)) ? x : acc};
            OP_RMIN: result = {1'b0, ($signed(x) < $signed(acc)) ? x : acc};
            default: result = {1'b0, acc};
        endcase
        return result;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       redOp_q, redOp_d;
    logic             redSat_q, redSat_d;
    logic [CNT_W-1:0] redLen_q, redLen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             accOvf_q, accOvf_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] outRes_q, outRes_d;
    logic             outOvf_q, outOvf_d;

    logic             canLoad;
    logic             isLast;
    logic             inReady;
    logic             accept;
    logic             isRedOp;
    logic [CNT_W-1:0] lenEff;
    logic [WIDTH:0]   elemResult;
    logic [WIDTH:0]   firstTerm;
    logic [WIDTH:0]   stepTerm;

    // Handshake decode: only beats that load the output register wait on back-pressure.
    always_comb begin
        canLoad    = !outValid_q || out_ready_i;
        isLast     = (cnt_q == (redLen_q - CNT_ONE));
        inReady    = ((state_q == STATE_RUN) && !isLast) ? 1'b1 : canLoad;
        accept     = in_valid_i && inReady;
        isRedOp    = (op_i == OP_ACC) || (op_i == OP_RMAX) ||
                     (op_i == OP_RMIN) || (op_i == OP_MAC);
        lenEff     = (red_len_i == '0) ? CNT_ONE : red_len_i;
        elemResult = elemOp(op_i, a_i, b_i, sat_i);
        firstTerm  = redFirst(op_i, a_i, b_i, sat_i);
        stepTerm   = redStep(redOp_q, acc_q, a_i, b_i, redSat_q);
    end

    // Next-state logic for the reduction controller and the output register.
    always_comb begin
        state_d    = state_q;
        redOp_d    = redOp_q;
        redSat_d   = redSat_q;
        redLen_d   = redLen_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        accOvf_d   = accOvf_q;
        outValid_d = outValid_q;
        outRes_d   = outRes_q;
        outOvf_d   = outOvf_q;

        if (outValid_q && out_ready_i) outValid_d = 1'b0;

        if (accept) begin
            if (state_q == STATE_IDLE) begin
                if (!isRedOp) begin
                    outValid_d = 1'b1;
                    outRes_d   = elemResult[WIDTH-1:0];
                    outOvf_d   = elemResult[WIDTH];
                end else if (lenEff == CNT_ONE) begin
                    acc_d      = firstTerm[WIDTH-1:0];
                    accOvf_d   = firstTerm[WIDTH];
                    outValid_d = 1'b1;
                    outRes_d   = firstTerm[WIDTH-1:0];
                    outOvf_d   = firstTerm[WIDTH];
                    cnt_d      = '0;
                end else begin
                    acc_d    = firstTerm[WIDTH-1:0];
                    accOvf_d = firstTerm[WIDTH];
                    redOp_d  = op_i;
                    redSat_d = sat_i;
                    redLen_d = lenEff;
                    cnt_d    = CNT_ONE;
                    state_d  = STATE_RUN;
                end
            end else begin
                acc_d    = stepTerm[WIDTH-1:0];
                accOvf_d = accOvf_q | stepTerm[WIDTH];
                if (isLast) begin
                    outValid_d = 1'b1;
                    outRes_d   = stepTerm[WIDTH-1:0];
                    outOvf_d   = accOvf_q | stepTerm[WIDTH];
                    cnt_d      = '0;
                    state_d    = STATE_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    // State registers; reset clears everything, including any partial reduction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= STATE_IDLE;
            redOp_q    <= OP_NOP;
            redSat_q   <= 1'b0;
            redLen_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            accOvf_q   <= 1'b0;
            outValid_q <= 1'b0;
            outRes_q   <= '0;
            outOvf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            redOp_q    <= redOp_d;
            redSat_q   <= redSat_d;
            redLen_q   <= redLen_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            accOvf_q   <= accOvf_d;
            outValid_q <= outValid_d;
            outRes_q   <= outRes_d;
            outOvf_q   <= outOvf_d;
        end
    end

    assign in_ready_o  = inReady;
    assign out_valid_o = outValid_q;
    assign res_o       = outRes_q;
    assign ovf_o       = outOvf_q;
    assign busy_o      = (state_q == STATE_RUN);

endmodule

// File: tb/tb_fu_pipe_wrapper.sv
// Directed bench for fu_pipe_wrapper: element-wise vector table plus
// hand-written reduction, back-pressure and reset sequences.
module tb_fu_pipe_wrapper;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_ARSH = 4'd4;
    localparam logic [3:0] OP_LRSH = 4'd5;
    localparam logic [3:0] OP_LSH  = 4'd6;
    localparam logic [3:0] OP_ACC  = 4'd7;
    localparam logic [3:0] OP_RMAX = 4'd8;
    localparam logic [3:0] OP_RMIN = 4'd9;
    localparam logic [3:0] OP_MAC  = 4'd10;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sat;
        logic [WIDTH-1:0] expRes;
        logic             expOvf;
    } vec_t;

    localparam int NUM_VECS = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       opIn;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             satIn;
    logic [CNT_W-1:0] redLen;
    logic             inValid;
    logic             inReady;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             busy;

    vec_t             vecs [NUM_VECS];
    logic [WIDTH-1:0] redA [8];
    logic [WIDTH-1:0] redB [8];

    int total = 0;
    int bad   = 0;

    fu_pipe_wrapper #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .op_i        (opIn),
        .a_i         (aIn),
        .b_i         (bIn),
        .sat_i       (satIn),
        .red_len_i   (redLen),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .res_o       (res),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Offer one beat and hold it until accepted, then return just after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic sat,
                                 input logic [CNT_W-1:0] len);
        int waited;
        @(negedge clk);
        opIn    = op;
        aIn     = a;
        bIn     = b;
        satIn   = sat;
        redLen  = len;
        inValid = 1'b1;
        waited  = 0;
        while (!inReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!inReady) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: got in_ready 0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Check that the beat just accepted produced the given output.
    task automatic checkBeat(input string name, input logic [WIDTH-1:0] expRes,
                             input logic expOvf);
        checkOutput({name, " valid"}, {31'd0, outValid}, 32'd1);
        checkOutput({name, " res"}, res, expRes);
        checkOutput({name, " ovf"}, {31'd0, ovf}, {31'd0, expOvf});
    endtask

    // Feed a whole reduction from redA/redB; later beats carry junk op/sat/len.
    task automatic runReduction(input string name, input logic [3:0] op, input logic sat,
                                input int len, input logic [WIDTH-1:0] expRes,
                                input logic expOvf);
        int n;
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            if (i == 0) applyStimulus(op, redA[i], redB[i], sat, CNT_W'(len));
            else        applyStimulus(OP_ADD, redA[i], redB[i], ~sat, 16'd3);
            if (i < n - 1) begin
                checkOutput({name, " busy mid"}, {31'd0, busy}, 32'd1);
                checkOutput({name, " no early beat"}, {31'd0, outValid}, 32'd0);
            end
        end
        checkBeat(name, expRes, expOvf);
        checkOutput({name, " busy end"}, {31'd0, busy}, 32'd0);
    endtask

    // Idle one cycle and confirm the previous result was delivered exactly once.
    task automatic idleCheck(input string name);
        @(posedge clk);
        #1;
        checkOutput({name, " single beat"}, {31'd0, outValid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'd1,          1'b1, 32'h7FFFFFFF, 1'b1};
        vecs[1]  = '{OP_ADD,  32'h7FFFFFFF, 32'd1,          1'b0, 32'h80000000, 1'b1};
        vecs[2]  = '{OP_ADD,  32'd5,        32'd3,          1'b1, 32'd8,        1'b0};
        vecs[3]  = '{OP_SUB,  32'h80000000, 32'd1,          1'b1, 32'h80000000, 1'b1};
        vecs[4]  = '{OP_SUB,  32'h80000000, 32'd1,          1'b0, 32'h7FFFFFFF, 1'b1};
        vecs[5]  = '{OP_SUB,  32'd3,        32'd5,          1'b0, 32'hFFFFFFFE, 1'b0};
        vecs[6]  = '{OP_MUL,  32'h00010000, 32'h00010000,   1'b1, 32'h7FFFFFFF, 1'b1};
        vecs[7]  = '{OP_MUL,  32'h00010000, 32'h00010000,   1'b0, 32'h00000000, 1'b1};
        vecs[8]  = '{OP_MUL,  32'hFFFFFFFD, 32'd7,          1'b1, 32'hFFFFFFEB, 1'b0};
        vecs[9]  = '{OP_MUL,  32'h80000000, 32'hFFFFFFFF,   1'b0, 32'h80000000, 1'b1};
        vecs[10] = '{OP_MUL,  32'hFFFF0000, 32'h00008000,   1'b1, 32'h80000000, 1'b0};
        vecs[11] = '{OP_ARSH, 32'h80000000, 32'h00000021,   1'b0, 32'hC0000000, 1'b0};
        vecs[12] = '{OP_LRSH, 32'h80000000, 32'd4,          1'b0, 32'h08000000, 1'b0};
        vecs[13] = '{OP_LSH,  32'd1,        32'd31,         1'b0, 32'h80000000, 1'b0};
        vecs[14] = '{OP_NOP,  32'h1234,     32'd5,          1'b0, 32'd0,        1'b0};
        vecs[15] = '{4'd12,   32'h1234,     32'd5,          1'b1, 32'd0,        1'b0};
        vecs[16] = '{OP_MUL,  32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h7FFFFFFF, 1'b1};

        rst      = 1'b1;
        opIn     = OP_NOP;
        aIn      = '0;
        bIn      = '0;
        satIn    = 1'b0;
        redLen   = '0;
        inValid  = 1'b0;
        outReady = 1'b1;

        #22;
        checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset res", res, 32'd0);
        checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post reset in_ready", {31'd0, inReady}, 32'd1);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sat, 16'd1);
            checkBeat($sformatf("vec%0d", i), vecs[i].expRes, vecs[i].expOvf);
        end
        idleCheck("vec tail");

        redA = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        redB = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("acc4", OP_ACC, 1'b0, 4, 32'd10, 1'b0);
        idleCheck("acc4");

        redA = '{32'd2, 32'd4, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        redB = '{32'd3, 32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("mac3", OP_MAC, 1'b0, 3, 32'd20, 1'b0);
        idleCheck("mac3");

        redA = '{32'd5, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("rmin3", OP_RMIN, 1'b0, 3, 32'hFFFFFFF9, 1'b0);
        idleCheck("rmin3");

        redA = '{32'hFFFFFFF8, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'hFFFFFFF7,
                 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("rmax4", OP_RMAX, 1'b0, 4, 32'hFFFFFFFD, 1'b0);
        idleCheck("rmax4");

        redA = '{32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("accsat", OP_ACC, 1'b1, 2, 32'h7FFFFFFF, 1'b1);
        idleCheck("accsat");

        redA = '{32'h7FFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("accwrap", OP_ACC, 1'b0, 3, 32'h7FFFFFFF, 1'b1);
        idleCheck("accwrap");

        redA = '{32'hFFFFFFFC, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("acclen0", OP_ACC, 1'b0, 0, 32'hFFFFFFFC, 1'b0);
        idleCheck("acclen0");

        redA = '{32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("acc2", OP_ACC, 1'b0, 2, 32'd7, 1'b0);
        @(negedge clk);
        checkOutput("elem after red ready", {31'd0, inReady}, 32'd1);
        applyStimulus(OP_ADD, 32'd1, 32'd1, 1'b0, 16'd1);
        checkBeat("elem after red", 32'd2, 1'b0);
        idleCheck("elem after red");

        @(negedge clk);
        outReady = 1'b0;
        opIn     = OP_ADD;
        aIn      = 32'd1;
        bIn      = 32'd1;
        satIn    = 1'b0;
        inValid  = 1'b1;
        @(posedge clk);
        #1;
        checkBeat("bp first", 32'd2, 1'b0);
        aIn = 32'd2;
        bIn = 32'd2;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp stall%0d ready", i), {31'd0, inReady}, 32'd0);
            checkOutput($sformatf("bp stall%0d res", i), res, 32'd2);
            checkOutput($sformatf("bp stall%0d valid", i), {31'd0, outValid}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkBeat("bp second", 32'd4, 1'b0);
        idleCheck("bp second");

        applyStimulus(OP_ACC, 32'd1, 32'd0, 1'b0, 16'd5);
        applyStimulus(OP_ACC, 32'd2, 32'd0, 1'b0, 16'd5);
        checkOutput("mid red busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", {31'd0, busy}, 32'd0);
        checkOutput("async rst valid", {31'd0, outValid}, 32'd0);
        checkOutput("async rst res", res, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst release ready", {31'd0, inReady}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("no beat after rst%0d", i), {31'd0, outValid}, 32'd0);
        end
        redA = '{32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        runReduction("acc1 after rst", OP_ACC, 1'b0, 1, 32'd9, 1'b0);
        idleCheck("acc1 after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
